ps2_keyboard_rx: RTL
====================

Name: ps2_keyboard_rx

Overview:
- Host-side PS/2 keyboard receiver feeding the `ps2_key[10:0]` input of the Ace top level and the keyboard matrix.
- Deserialises device-to-host PS/2 frames, validates them, and folds E0/F0 prefixes into a single key event.
- Presents each event as a toggle-strobed 11-bit word: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
- Clocked on the CPU clock domain, the same clock as the keyboard matrix.

Parameters:
- FILTER_LEN, 4: consecutive equal samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 8192: clk cycles without a falling edge mid-frame before the frame is aborted.
- PAUSE_SKIP, 7: bytes discarded after an E1 prefix.

Ports:
- clk  in  1  system clock (clkcpu).
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- ps2_key  out  11  key event word: [10] toggle, [9] pressed, [8] extended, [7:0] code.
- frame_err  out  1  one-cycle pulse on a parity, start or stop error, or on a timeout.
- busy  out  1  high while a frame is in progress (bit count nonzero).

Behaviour:
- Reset (async, reset_n=0):
  - ps2_key=0, frame_err=0, busy=0.
  - Bit counter=0; ext, rel and skip count cleared.
  - Filtered clock=1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - Filtered clock takes a new level only after FILTER_LEN consecutive identical synchronised samples.
  - A falling edge is filtered clock 1->0. On that cycle, synchronised ps2_data is sampled.
- Frame FSM, states IDLE/SHIFT/CHECK:
  - IDLE: first falling edge captures bit0 (start), goes to SHIFT, count=1.
  - SHIFT: each falling edge shifts bits 1..10. Order: 8 data bits LSB first, odd parity, stop. When count reaches 11, go to CHECK.
  - CHECK (one cycle): frame is valid iff start=0, stop=1, and XOR of data and parity = 1. Return to IDLE, count=0.
  - Invalid frame: frame_err=1 for one cycle, byte discarded, ext/rel cleared.
  - Timeout: in SHIFT with no falling edge for TIMEOUT_CYCLES, return to IDLE, count=0, frame_err pulse, ext/rel cleared. The timer restarts on every falling edge.
- Byte decoder (runs on a valid byte in the CHECK cycle):
  - skip count >0: decrement, ignore byte.
  - E1: skip=PAUSE_SKIP, clear ext/rel.
  - E0: ext=1.
  - F0: rel=1.
  - AA, FA, EE, FE, 00, FF: ignored; ext/rel cleared.
  - Any other byte: ps2_key <= {~ps2_key[10], ~rel, ext, byte}, then ext=rel=0.
- Latency: ps2_key updates on the clk edge ending CHECK, i.e. 2 cycles after the 11th falling edge is detected. Bits [9:0] and the toggle change in the same cycle, so the consumer may sample on toggle change.
- ps2_key holds its value between events; only bit 10 signals a new event.
- Simultaneous timeout expiry and falling edge: the edge wins (timer reset, bit accepted).
- reset_n asserted mid-frame: all state is cleared immediately. The partial frame is lost with no frame_err; the next complete frame decodes normally.
- A filtered-clock glitch shorter than FILTER_LEN cycles produces no edge.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_EXT=8'hE0, PS2_REL=8'hF0, PS2_PAUSE=8'hE1;
  - the ignore-list codes;
  - PS2_FRAME_BITS=11;
  - the ps2_key field index localparams (TOGGLE=10, PRESSED=9, EXT=8).
- Sub-module ps2_frame_rx contains the synchroniser, filter, bit FSM, parity check and timeout. It outputs byte, byte_valid and err pulses.
- The top of ps2_keyboard_rx is the prefix decoder and the output register.

Test Plan:
- Send frame 0x1C (parity 0, stop 1), 30 us bit period -> ps2_key 11'h000 -> 11'h61C (toggle 1, pressed 1, code 1C); frame_err stays 0.
- Send F0 then 1C -> exactly one toggle; ps2_key[9:0]=10'h01C (pressed 0, ext 0).
- Send E0, 75 -> ps2_key[9:0]=10'h375; then E0, F0, 75 -> ps2_key[9:0]=10'h175; two toggles total.
- Send 0x1C with wrong parity -> one-cycle frame_err, no toggle; then E0 followed by a bad frame, then 1C -> ps2_key[8]=0 (ext cleared).
- Send 5 bits then stall for TIMEOUT_CYCLES+1 -> frame_err pulse, busy 1->0; the next 0x29 frame decodes to [9:0]=10'h229.
- Send pause sequence E1 14 77 E1 F0 14 F0 77 -> no toggle. Inject a 2-cycle low glitch on ps2_clk while idle -> busy stays 0. Assert reset_n mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a; PS/2 is device-clocked and cannot be throttled by the host.
package ps2_pkg;

  // Prefix bytes folded into the following key event
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_REL   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Device status/response bytes that never represent a key
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_OVF0   = 8'h00;
  localparam logic [7:0] PS2_OVF1   = 8'hFF;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  // ps2_key field positions
  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } frame_state_t;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK)  || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_OVF0) || (b == PS2_OVF1);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: sync, clock glitch filter, 11-bit shift FSM, parity/start/stop check, timeout.
// Latency: byte_vld asserts in the CHECK cycle, one cycle after the 11th filtered falling edge.
// Backpressure: none; byte_vld/err are single-cycle pulses the consumer must take.
// Ports: clk, reset_n (async active-low), ps2_clk/ps2_data (raw async lines),
//        byte_dat/byte_vld (received byte strobe), err (frame error or timeout pulse), busy (bit count nonzero).
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_dat,
  output logic       byte_vld,
  output logic       err,
  output logic       busy
);
  import ps2_pkg::*;

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic                clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic                filt_q, filt_d;
  logic [FW-1:0]       filt_cnt_q, filt_cnt_d;
  logic                fall;
  frame_state_t        state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [10:0]         sreg_q, sreg_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                frame_ok;
  logic                timeout;

  // The filtered clock only flips after FILTER_LEN consecutive samples
  // disagree with it; any agreeing sample restarts the run.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
        fall   = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Bits arrive LSB first and are shifted in at the top, so after 11 edges
  // sreg_q[0] is start, [8:1] data, [9] parity, [10] stop.
  assign frame_ok = ~sreg_q[0] & sreg_q[10] & (^sreg_q[9:1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    timer_d = timer_q;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (fall) begin
          sreg_d  = {dat_sync_q, 10'b0};
          cnt_d   = 4'd1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A falling edge takes priority over a timer expiring the same cycle
        if (fall) begin
          sreg_d  = {dat_sync_q, sreg_q[10:1]};
          cnt_d   = cnt_q + 4'd1;
          timer_d = '0;
          if (cnt_q == 4'(PS2_FRAME_BITS - 1)) state_d = ST_CHECK;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          timer_d = '0;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_CHECK: begin
        timer_d = '0;
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
      default: begin
        timer_d = '0;
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      sreg_q     <= '0;
      timer_q    <= '0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      timer_q    <= timer_d;
    end
  end

  assign byte_dat = sreg_q[8:1];
  assign byte_vld = (state_q == ST_CHECK) &&  frame_ok;
  assign err      = ((state_q == ST_CHECK) && !frame_ok) || timeout;
  assign busy     = (cnt_q != 4'd0);

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: folds E0/F0/E1 prefixes into a toggle-strobed 11-bit key event word.
// Latency: ps2_key updates on the edge ending CHECK (2 cycles after the 11th filtered falling edge).
// Backpressure: none; consumer detects new events by a change of ps2_key[10].
// Ports: clk, reset_n (async active-low), ps2_clk/ps2_data (raw lines),
//        ps2_key {toggle, pressed, extended, code}, frame_err (1-cycle error pulse), busy (frame in progress).
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int PAUSE_SKIP     = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);
  import ps2_pkg::*;

  localparam int SW = $clog2(PAUSE_SKIP + 1);

  logic [7:0]    byte_dat;
  logic          byte_vld;
  logic          rx_err;
  logic          rx_busy;

  logic [10:0]   key_q, key_d;
  logic          err_q, err_d;
  logic          ext_q, ext_d;
  logic          rel_q, rel_d;
  logic [SW-1:0] skip_q, skip_d;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byte_dat (byte_dat),
    .byte_vld (byte_vld),
    .err      (rx_err),
    .busy     (rx_busy)
  );

  always_comb begin
    key_d  = key_q;
    err_d  = rx_err;
    ext_d  = ext_q;
    rel_d  = rel_q;
    skip_d = skip_q;
    if (rx_err) begin
      // A lost byte may have been a prefix or the key itself; drop pending prefixes
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (byte_vld) begin
      if (skip_q != '0) begin
        // Pause/Break sends a fixed-length sequence with no break code; swallow it
        skip_d = skip_q - 1'b1;
      end else if (byte_dat == PS2_PAUSE) begin
        skip_d = SW'(PAUSE_SKIP);
        ext_d  = 1'b0;
        rel_d  = 1'b0;
      end else if (byte_dat == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (byte_dat == PS2_REL) begin
        rel_d = 1'b1;
      end else if (is_ignored(byte_dat)) begin
        ext_d = 1'b0;
        rel_d = 1'b0;
      end else begin
        key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
        key_d[KEY_PRESSED] = ~rel_q;
        key_d[KEY_EXT]     = ext_q;
        key_d[7:0]         = byte_dat;
        ext_d              = 1'b0;
        rel_d              = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q  <= '0;
      err_q  <= 1'b0;
      ext_q  <= 1'b0;
      rel_q  <= 1'b0;
      skip_q <= '0;
    end else begin
      key_q  <= key_d;
      err_q  <= err_d;
      ext_q  <= ext_d;
      rel_q  <= rel_d;
      skip_q <= skip_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;
  assign busy      = rx_busy;

endmodule
